complex_dot_initiator: RTL and testbench

Initiator-side controller for the complex multiplier's valid/ready operand/result interface. It accepts a command giving a vector length N, streams N operand packets from an upstream sample port into the multiplier, and collects the N complex products. It accumulates the products into a complex dot-product sum and presents the sum on an output handshake. It sits between the sample source and the multiplier, and owns both ends of the multiplier's protocol.

---
 rtl/complex_pkg.sv | 23 ++
 rtl/cplx_acc.sv | 39 +++
 rtl/complex_dot_initiator.sv | 121 ++++++++++++
 tb/tb_complex_dot_initiator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// rtl/complex_pkg.sv - shared widths, packing order and FSM states for the complex dot-product initiator
package complex_pkg;

  localparam int OP_W      = 8;
  localparam int RES_W     = 18;
  // Operand packet {x1, y1, x2, y2}, result packet {re, im}, MSB first
  localparam int OP_PKT_W  = 4 * OP_W;
  localparam int RES_PKT_W = 2 * RES_W;
  localparam int RE_LSB    = RES_W;
  localparam int IM_LSB    = 0;

  // One accumulator bit of headroom per length bit keeps a full-length sum exact
  function automatic int acc_w(input int len_w);
    return RES_W + len_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cplx_acc.sv
// rtl/cplx_acc.sv - clearable signed complex accumulator with product sign-extension
module cplx_acc
  import complex_pkg::*;
#(
  parameter int ACC_W = 26
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_add_en,
  input  logic [RES_PKT_W-1:0] i_data,
  output logic [2*ACC_W-1:0]   o_acc
);

  logic [RES_W-1:0] w_re;
  logic [RES_W-1:0] w_im;
  logic [ACC_W-1:0] w_re_ext;
  logic [ACC_W-1:0] w_im_ext;
  logic [ACC_W-1:0] r_re;
  logic [ACC_W-1:0] r_im;

  assign w_re     = i_data[RE_LSB +: RES_W];
  assign w_im     = i_data[IM_LSB +: RES_W];
  assign w_re_ext = {{(ACC_W-RES_W){w_re[RES_W-1]}}, w_re};
  assign w_im_ext = {{(ACC_W-RES_W){w_im[RES_W-1]}}, w_im};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_re <= '0;
      r_im <= '0;
    end else if (i_add_en) begin
      r_re <= r_re + w_re_ext;
      r_im <= r_im + w_im_ext;
    end
  end

  assign o_acc = {r_re, r_im};

endmodule

// File: rtl/complex_dot_initiator.sv
// rtl/complex_dot_initiator.sv - streams N operand packets to the complex multiplier and sums the N products
module complex_dot_initiator
  import complex_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cmd_val,
  output logic                          o_cmd_rdy,
  input  logic [LEN_W-1:0]              i_cmd_len,
  input  logic                          i_smp_val,
  output logic                          o_smp_rdy,
  input  logic [OP_PKT_W-1:0]           i_smp_data,
  output logic                          o_op_val,
  input  logic                          i_op_rdy,
  output logic [OP_PKT_W-1:0]           o_op_data,
  input  logic                          i_res_val,
  output logic                          o_res_rdy,
  input  logic [RES_PKT_W-1:0]          i_res_data,
  output logic                          o_acc_val,
  input  logic                          i_acc_rdy,
  output logic [2*acc_w(LEN_W)-1:0]     o_acc_data
);

  localparam int ACC_W = acc_w(LEN_W);

  state_e              r_state;
  state_e              w_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_iss_cnt;
  logic [LEN_W-1:0]    r_rcv_cnt;
  logic                r_op_val;
  logic [OP_PKT_W-1:0] r_op_data;

  logic w_cmd_acc;
  logic w_smp_acc;
  logic w_res_acc;
  logic w_op_xfer;

  assign w_cmd_acc = o_cmd_rdy & i_cmd_val;
  assign w_smp_acc = o_smp_rdy & i_smp_val;
  assign w_res_acc = o_res_rdy & i_res_val;
  assign w_op_xfer = r_op_val & i_op_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_cmd_rdy = 1'b0;
    o_smp_rdy = 1'b0;
    o_res_rdy = 1'b0;
    o_acc_val = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Masked during reset so cmd_rdy first rises the cycle rst drops
        o_cmd_rdy = !i_rst;
        if (i_cmd_val && !i_rst)
          w_next = (i_cmd_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        o_smp_rdy = (r_iss_cnt < r_len) && (!r_op_val || i_op_rdy);
        // Multiplier holds a result for one cycle only, so never backpressure it
        o_res_rdy = (r_rcv_cnt < r_len);
        if (o_res_rdy && i_res_val && (r_rcv_cnt == r_len - LEN_W'(1)))
          w_next = ST_DONE;
      end
      ST_DONE: begin
        o_acc_val = 1'b1;
        if (i_acc_rdy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len     <= '0;
      r_iss_cnt <= '0;
      r_rcv_cnt <= '0;
    end else if (w_cmd_acc) begin
      r_len     <= i_cmd_len;
      r_iss_cnt <= '0;
      r_rcv_cnt <= '0;
    end else begin
      if (w_smp_acc) r_iss_cnt <= r_iss_cnt + LEN_W'(1);
      if (w_res_acc) r_rcv_cnt <= r_rcv_cnt + LEN_W'(1);
    end
  end

  // A new sample takes priority over draining the current one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_val  <= 1'b0;
      r_op_data <= '0;
    end else if (w_smp_acc) begin
      r_op_val  <= 1'b1;
      r_op_data <= i_smp_data;
    end else if (w_op_xfer) begin
      r_op_val  <= 1'b0;
    end
  end

  assign o_op_val  = r_op_val;
  assign o_op_data = r_op_data;

  cplx_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_cmd_acc),
    .i_add_en(w_res_acc),
    .i_data  (i_res_data),
    .o_acc   (o_acc_data)
  );

endmodule

// File: tb/tb_complex_dot_initiator.sv
// tb/tb_complex_dot_initiator.sv - directed bench with a 1-cycle complex multiplier model
module tb_complex_dot_initiator;

  localparam int LEN_W = 8;
  localparam int ACC_W = 18 + LEN_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_val;
  logic                 cmd_rdy;
  logic [LEN_W-1:0]     cmd_len;
  logic                 smp_val;
  logic                 smp_rdy;
  logic [31:0]          smp_data;
  logic                 op_val;
  logic                 op_rdy;
  logic [31:0]          op_data;
  logic                 res_val;
  logic                 res_rdy;
  logic [35:0]          res_data;
  logic                 acc_val;
  logic                 acc_rdy;
  logic [2*ACC_W-1:0]   acc_data;

  logic signed [ACC_W-1:0] a_re;
  logic signed [ACC_W-1:0] a_im;
  assign a_re = acc_data[2*ACC_W-1:ACC_W];
  assign a_im = acc_data[ACC_W-1:0];

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] smp_q[$];

  always #5 clk = ~clk;

  complex_dot_initiator #(.LEN_W(LEN_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cmd_val (cmd_val),
    .o_cmd_rdy (cmd_rdy),
    .i_cmd_len (cmd_len),
    .i_smp_val (smp_val),
    .o_smp_rdy (smp_rdy),
    .i_smp_data(smp_data),
    .o_op_val  (op_val),
    .i_op_rdy  (op_rdy),
    .o_op_data (op_data),
    .i_res_val (res_val),
    .o_res_rdy (res_rdy),
    .i_res_data(res_data),
    .o_acc_val (acc_val),
    .i_acc_rdy (acc_rdy),
    .o_acc_data(acc_data)
  );

  function automatic logic [35:0] cmul(input logic [31:0] d);
    logic signed [7:0] x1, y1, x2, y2;
    int re, im;
    x1 = d[31:24]; y1 = d[23:16]; x2 = d[15:8]; y2 = d[7:0];
    re = int'(x1) * int'(x2) - int'(y1) * int'(y2);
    im = int'(x1) * int'(y2) + int'(y1) * int'(x2);
    return {18'(re), 18'(im)};
  endfunction

  // Multiplier model: result valid for exactly one cycle after an operand transfer
  always @(posedge clk) begin
    if (rst) begin
      res_val  <= 1'b0;
      res_data <= '0;
    end else begin
      res_val  <= op_val && op_rdy;
      res_data <= cmul(op_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int n, input bit gaps, input bit stalls,
                         input int exp_re, input int exp_im, input int exp_lat);
    int idx, xfers, last_res, seen;
    chk({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'(1));
    cmd_val = 1'b1;
    cmd_len = LEN_W'(n);
    @(posedge clk); #1;
    cmd_val  = 1'b0;
    idx      = 0;
    xfers    = 0;
    last_res = -100;
    seen     = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      smp_val  = (idx < n) && (!gaps || ($urandom_range(0, 2) != 0));
      smp_data = (idx < n) ? smp_q[idx] : 32'h0;
      op_rdy   = !stalls || ($urandom_range(0, 1) == 1);
      #1;
      if (acc_val) begin
        seen = cyc;
        break;
      end
      if (smp_val && smp_rdy) idx++;
      if (op_val && op_rdy) xfers++;
      if (res_val && res_rdy) last_res = cyc;
      @(posedge clk); #1;
    end
    smp_val = 1'b0;
    op_rdy  = 1'b1;
    chk({tag, "_done"}, 64'(seen >= 0), 64'(1));
    chk({tag, "_op_xfers"}, 64'(xfers), 64'(n));
    chk({tag, "_acc_re"}, 64'(a_re), 64'(exp_re));
    chk({tag, "_acc_im"}, 64'(a_im), 64'(exp_im));
    chk({tag, "_res_to_acc"}, 64'(seen - last_res), 64'(1));
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(seen), 64'(exp_lat));
  endtask

  task automatic acc_take(input string tag);
    acc_rdy = 1'b1;
    @(posedge clk); #1;
    acc_rdy = 1'b0;
    chk({tag, "_acc_val_drop"}, 64'(acc_val), 64'(0));
    chk({tag, "_cmd_rdy_back"}, 64'(cmd_rdy), 64'(1));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'(0));
    chk({tag, "_smp_rdy"}, 64'(smp_rdy), 64'(0));
    chk({tag, "_op_val"}, 64'(op_val), 64'(0));
    chk({tag, "_op_data"}, 64'(op_data), 64'(0));
    chk({tag, "_res_rdy"}, 64'(res_rdy), 64'(0));
    chk({tag, "_acc_val"}, 64'(acc_val), 64'(0));
    chk({tag, "_acc_data"}, 64'(acc_data), 64'(0));
  endtask

  initial begin
    logic [2*ACC_W-1:0] held;
    int rcv;
    rst = 1'b1; cmd_val = 1'b0; cmd_len = '0; smp_val = 1'b0; smp_data = '0;
    op_rdy = 1'b1; acc_rdy = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("por_cmd_rdy_rise", 64'(cmd_rdy), 64'(1));

    smp_q = '{32'h03020104};
    run_vec("n1", 1, 1'b0, 1'b0, -5, 14, 3);
    acc_take("n1");

    smp_q = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
    run_vec("n4", 4, 1'b0, 1'b0, 0, 8, 6);
    acc_take("n4");

    smp_q.delete();
    for (int i = 0; i < 255; i++) smp_q.push_back(32'h80808080);
    run_vec("n255", 255, 1'b0, 1'b0, 0, 8355840, 257);
    acc_take("n255");

    smp_q = '{32'h01000100, 32'h00010001, 32'h02020202};
    run_vec("n3_stall", 3, 1'b1, 1'b1, 0, 8, -1);

    held = acc_data;
    for (int i = 0; i < 10; i++) begin
      smp_val  = 1'b1;
      smp_data = 32'h7f7f7f7f;
      @(posedge clk); #1;
      chk("hold_acc_val", 64'(acc_val), 64'(1));
      chk("hold_acc_data", 64'(acc_data), 64'(held));
      chk("hold_cmd_rdy", 64'(cmd_rdy), 64'(0));
      chk("hold_smp_rdy", 64'(smp_rdy), 64'(0));
    end
    smp_val = 1'b0;
    acc_take("n3_stall");

    cmd_val = 1'b1;
    cmd_len = '0;
    @(posedge clk); #1;
    cmd_val = 1'b0;
    chk("n0_acc_val", 64'(acc_val), 64'(1));
    chk("n0_acc_data", 64'(acc_data), 64'(0));
    acc_take("n0");

    smp_q = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
    cmd_val = 1'b1;
    cmd_len = LEN_W'(5);
    @(posedge clk); #1;
    cmd_val = 1'b0;
    rcv = 0;
    for (int cyc = 0; cyc < 50 && rcv < 2; cyc++) begin
      smp_val  = 1'b1;
      smp_data = 32'h01010101;
      #1;
      if (res_val && res_rdy) rcv++;
      @(posedge clk); #1;
    end
    chk("rst_mid_two_products", 64'(rcv), 64'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("rst_mid");
    rst     = 1'b0;
    smp_val = 1'b0;
    #1;
    chk("rst_mid_cmd_rdy_rise", 64'(cmd_rdy), 64'(1));
    smp_q = '{32'h02000300};
    run_vec("post_rst", 1, 1'b0, 1'b0, 6, 0, 3);
    acc_take("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
